// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and constants for the sprite overlay path
package gpu_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int GPU_X_W = 10;
    localparam int GPU_Y_W = 9;

    // One sprite register set as seen by software
    typedef struct packed {
        logic               en;
        logic [GPU_X_W-1:0] x;
        logic [GPU_Y_W-1:0] y;
    } sprite_cfg_t;

    // Colour treated as transparent in sprite textures
    localparam rgb12_t KEY_DEFAULT = 12'h000;

    // Pixel-in to colour-out latency; sync signals are delayed by this much
    localparam int SPR_PIPE_LAT = 3;

    // Index width that stays legal for single-entry cases
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// rtl/sprite_hit_unit.sv - per-sprite hit test and texture address, first pipeline stage
module sprite_hit_unit #(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int AW     = 2,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    i_px_x,
    input  logic [Y_W-1:0]    i_px_y,
    input  logic              i_spr_en,
    input  logic [X_W-1:0]    i_spr_x,
    input  logic [Y_W-1:0]    i_spr_y,
    input  logic [AW-1:0]     i_anim,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr
);

    // One extra bit so that right/bottom edges past the screen do not wrap
    localparam int XE = X_W + 1;
    localparam int YE = Y_W + 1;

    logic [XE-1:0]     w_px_x_e, w_left, w_right;
    logic [YE-1:0]     w_px_y_e, w_top, w_bottom;
    logic [X_W-1:0]    w_dx;
    logic [Y_W-1:0]    w_dy;
    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;

    logic              r_hit;
    logic [ADDR_W-1:0] r_addr;

    assign w_px_x_e = {1'b0, i_px_x};
    assign w_left   = {1'b0, i_spr_x};
    assign w_right  = w_left + XE'(SPR_W);
    assign w_px_y_e = {1'b0, i_px_y};
    assign w_top    = {1'b0, i_spr_y};
    assign w_bottom = w_top + YE'(SPR_H);

    assign w_hit = i_spr_en
                && (w_px_x_e >= w_left) && (w_px_x_e < w_right)
                && (w_px_y_e >= w_top)  && (w_px_y_e < w_bottom);

    // Offsets are only meaningful on a hit; a miss forces the address to zero
    assign w_dx = i_px_x - i_spr_x;
    assign w_dy = i_px_y - i_spr_y;

    // Frames are stacked vertically in the texture; arithmetic wraps at ADDR_W
    assign w_addr = (ADDR_W'(w_dy) + ADDR_W'(i_anim) * ADDR_W'(SPR_H)) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_dx);

    // Register hit flag and ROM address for the texture fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit  <= 1'b0;
            r_addr <= '0;
        end else begin
            r_hit  <= w_hit;
            r_addr <= w_hit ? w_addr : '0;
        end
    end

    assign o_hit  = r_hit;
    assign o_addr = r_addr;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - multi-sprite overlay with priority, colour key and collision flag
module sprite_compositor
    import gpu_pkg::*;
#(
    parameter int     NUM_SPRITES = 4,
    parameter int     SPR_W       = 64,
    parameter int     SPR_H       = 64,
    parameter int     NUM_FRAMES  = 4,
    parameter int     ANIM_SHIFT  = 4,
    parameter int     X_W         = 10,
    parameter int     Y_W         = 9,
    parameter int     ADDR_W      = 14,
    parameter rgb12_t KEY         = KEY_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [X_W-1:0]                px_x,
    input  logic [Y_W-1:0]                px_y,
    input  logic                          visible,
    input  logic                          frame_start,
    input  logic [11:0]                   bg_rgb,
    input  logic                          cfg_we,
    input  logic [idx_width(NUM_SPRITES)-1:0] cfg_idx,
    input  logic                          cfg_en,
    input  logic [X_W-1:0]                cfg_x,
    input  logic [Y_W-1:0]                cfg_y,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*12-1:0]     rom_data,
    output logic [11:0]                   rgb_out,
    output logic                          valid_out,
    output logic [idx_width(NUM_SPRITES):0] hit_id,
    output logic                          collision
);

    localparam int IW  = idx_width(NUM_SPRITES);
    localparam int AW  = idx_width(NUM_FRAMES);
    localparam int FCW = ANIM_SHIFT + AW;
    // Stages bg/visible travel before meeting rom_data
    localparam int DLY = SPR_PIPE_LAT - 1;

    // Register banks: software writes pending, pixels read active
    logic           r_pend_en [NUM_SPRITES];
    logic [X_W-1:0] r_pend_x  [NUM_SPRITES];
    logic [Y_W-1:0] r_pend_y  [NUM_SPRITES];
    logic           r_act_en  [NUM_SPRITES];
    logic [X_W-1:0] r_act_x   [NUM_SPRITES];
    logic [Y_W-1:0] r_act_y   [NUM_SPRITES];

    logic           w_next_en [NUM_SPRITES];
    logic [X_W-1:0] w_next_x  [NUM_SPRITES];
    logic [Y_W-1:0] w_next_y  [NUM_SPRITES];

    logic [FCW-1:0] r_frame_cnt;
    logic [AW-1:0]  w_anim;

    logic [NUM_SPRITES-1:0] w_hit;
    logic [ADDR_W-1:0]      w_addr [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] r_hit_d2;
    logic [11:0]            r_bg_pipe  [DLY];
    logic                   r_vis_pipe [DLY];

    logic [NUM_SPRITES-1:0] w_opaque;
    logic [IW-1:0]          w_win_idx;
    logic [11:0]            w_win_rgb;
    logic                   w_any;
    logic                   w_multi;

    logic [11:0]            r_rgb;
    logic                   r_valid;
    logic [IW:0]            r_hit_id;
    logic                   r_collision;

    // Pending bank with this cycle's write folded in, so a write that lands with frame_start is copied
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_next_en[i] = r_pend_en[i];
            w_next_x[i]  = r_pend_x[i];
            w_next_y[i]  = r_pend_y[i];
            if (cfg_we && (32'(cfg_idx) == i)) begin
                w_next_en[i] = cfg_en;
                w_next_x[i]  = cfg_x;
                w_next_y[i]  = cfg_y;
            end
        end
    end

    // Bank update: pending every cycle, active only on frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pend_en[i] <= 1'b0;
                r_pend_x[i]  <= '0;
                r_pend_y[i]  <= '0;
                r_act_en[i]  <= 1'b0;
                r_act_x[i]   <= '0;
                r_act_y[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pend_en[i] <= w_next_en[i];
                r_pend_x[i]  <= w_next_x[i];
                r_pend_y[i]  <= w_next_y[i];
                if (frame_start) begin
                    r_act_en[i] <= w_next_en[i];
                    r_act_x[i]  <= w_next_x[i];
                    r_act_y[i]  <= w_next_y[i];
                end
            end
        end
    end

    // Frame counter driving the shared animation index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + FCW'(1);
        end
    end

    assign w_anim = r_frame_cnt[ANIM_SHIFT +: AW];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        sprite_hit_unit #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .X_W    (X_W),
            .Y_W    (Y_W),
            .AW     (AW),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .clk      (clk),
            .rst      (rst),
            .i_px_x   (px_x),
            .i_px_y   (px_y),
            .i_spr_en (r_act_en[g]),
            .i_spr_x  (r_act_x[g]),
            .i_spr_y  (r_act_y[g]),
            .i_anim   (w_anim),
            .o_hit    (w_hit[g]),
            .o_addr   (w_addr[g])
        );
        assign rom_addr[g*ADDR_W +: ADDR_W] = w_addr[g];
    end

    // Align hit flags, background and visible with the ROM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_d2 <= '0;
            for (int s = 0; s < DLY; s++) begin
                r_bg_pipe[s]  <= '0;
                r_vis_pipe[s] <= 1'b0;
            end
        end else begin
            r_hit_d2      <= w_hit;
            r_bg_pipe[0]  <= bg_rgb;
            r_vis_pipe[0] <= visible;
            for (int s = 1; s < DLY; s++) begin
                r_bg_pipe[s]  <= r_bg_pipe[s-1];
                r_vis_pipe[s] <= r_vis_pipe[s-1];
            end
        end
    end

    // Opacity, lowest-index-wins priority and multi-hit detection
    always_comb begin
        w_opaque  = '0;
        w_win_idx = '0;
        w_win_rgb = r_bg_pipe[DLY-1];
        w_any     = 1'b0;
        w_multi   = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_opaque[i] = r_hit_d2[i] && (rom_data[i*12 +: 12] != KEY);
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_win_idx = IW'(i);
                w_win_rgb = rom_data[i*12 +: 12];
            end
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_opaque[i]) begin
                if (w_any) begin
                    w_multi = 1'b1;
                end
                w_any = 1'b1;
            end
        end
    end

    // Output register; blanked pixels produce all-zero outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb    <= '0;
            r_valid  <= 1'b0;
            r_hit_id <= '0;
        end else if (r_vis_pipe[DLY-1]) begin
            r_rgb    <= w_win_rgb;
            r_valid  <= 1'b1;
            r_hit_id <= w_any ? {1'b1, w_win_idx} : '0;
        end else begin
            r_rgb    <= '0;
            r_valid  <= 1'b0;
            r_hit_id <= '0;
        end
    end

    // Sticky collision flag; a set in the same cycle as the frame clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else if (r_vis_pipe[DLY-1] && w_multi) begin
            r_collision <= 1'b1;
        end else if (frame_start) begin
            r_collision <= 1'b0;
        end
    end

    assign rgb_out   = r_rgb;
    assign valid_out = r_valid;
    assign hit_id    = r_hit_id;
    assign collision = r_collision;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed bench for sprite_compositor
`timescale 1ns/1ps
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic        visible;
    logic        frame_start;
    logic [11:0] bg_rgb;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [9:0]  cfg_x;
    logic [8:0]  cfg_y;
    logic [55:0] rom_addr;
    logic [47:0] rom_data;
    logic [11:0] rgb_out;
    logic        valid_out;
    logic [2:0]  hit_id;
    logic        collision;

    logic [3:0]  tr;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          fs_count = 0;

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .px_x        (px_x),
        .px_y        (px_y),
        .visible     (visible),
        .frame_start (frame_start),
        .bg_rgb      (bg_rgb),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rgb_out     (rgb_out),
        .valid_out   (valid_out),
        .hit_id      (hit_id),
        .collision   (collision)
    );

    function automatic logic [11:0] spr_col(input int i);
        case (i)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            default: return 12'hFF0;
        endcase
    endfunction

    // Registered texture ROM: solid colour per sprite, or the key when tr[i] is set
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rom_data[i*12 +: 12] <= tr[i] ? 12'h000 : spr_col(i);
        end
    end

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        vis;
        logic [11:0] bg;
        logic [3:0]  tr;
        logic [11:0] rgb;
        logic [2:0]  hid;
        logic        vout;
        logic [13:0] a0, a1, a2, a3;
    } vec_t;

    vec_t vt [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pix(input logic [9:0] x, input logic [8:0] y, input logic v,
                       input logic [11:0] bg, input logic [3:0] t);
        px_x = x; px_y = y; visible = v; bg_rgb = bg; tr = t;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fs_count++;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [9:0] x, input logic [8:0] y);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_x = x; cfg_y = y;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic tick3();
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
        pix(10'd0, 9'd0, 1'b0, 12'h000, 4'h0);

        vt[0]  = '{10'd100,  9'd50,  1'b1, 12'h123, 4'h0, 12'hF00, 3'b100, 1'b1, 14'd0,    14'd0,    14'd0,    14'd0};
        vt[1]  = '{10'd164,  9'd50,  1'b1, 12'h5A5, 4'h0, 12'h5A5, 3'b000, 1'b1, 14'd0,    14'd0,    14'd0,    14'd0};
        vt[2]  = '{10'd163,  9'd113, 1'b1, 12'h111, 4'h0, 12'hF00, 3'b100, 1'b1, 14'd4095, 14'd3425, 14'd0,    14'd0};
        vt[3]  = '{10'd163,  9'd113, 1'b1, 12'h111, 4'h1, 12'h0F0, 3'b101, 1'b1, 14'd4095, 14'd3425, 14'd0,    14'd0};
        vt[4]  = '{10'd163,  9'd113, 1'b1, 12'h111, 4'h3, 12'h111, 3'b000, 1'b1, 14'd4095, 14'd3425, 14'd0,    14'd0};
        vt[5]  = '{10'd140,  9'd70,  1'b0, 12'h222, 4'h0, 12'h000, 3'b000, 1'b0, 14'd1320, 14'd650,  14'd0,    14'd0};
        vt[6]  = '{10'd5,    9'd200, 1'b1, 12'h333, 4'h0, 12'h333, 3'b000, 1'b1, 14'd0,    14'd0,    14'd0,    14'd0};
        vt[7]  = '{10'd1020, 9'd210, 1'b1, 12'h444, 4'h0, 12'h00F, 3'b110, 1'b1, 14'd0,    14'd0,    14'd660,  14'd0};
        vt[8]  = '{10'd1023, 9'd263, 1'b1, 12'h444, 4'h0, 12'h00F, 3'b110, 1'b1, 14'd0,    14'd0,    14'd4055, 14'd0};
        vt[9]  = '{10'd1023, 9'd264, 1'b1, 12'h555, 4'h0, 12'h555, 3'b000, 1'b1, 14'd0,    14'd0,    14'd0,    14'd0};
        vt[10] = '{10'd0,    9'd0,   1'b1, 12'hABC, 4'h0, 12'hABC, 3'b000, 1'b1, 14'd0,    14'd0,    14'd0,    14'd0};

        tick(); tick();
        chk("reset rgb_out",   32'(rgb_out),   32'h0);
        chk("reset valid_out", 32'(valid_out), 32'h0);
        chk("reset hit_id",    32'(hit_id),    32'h0);
        chk("reset collision", 32'(collision), 32'h0);
        chk("reset rom_addr",  32'(rom_addr[31:0]), 32'h0);
        rst = 1'b0;

        cfg(2'd0, 1'b1, 10'd100,  9'd50);
        cfg(2'd1, 1'b1, 10'd130,  9'd60);
        cfg(2'd2, 1'b1, 10'd1000, 9'd200);
        cfg(2'd3, 1'b0, 10'd0,    9'd0);
        fs_pulse();

        for (int v = 0; v < 11; v++) begin
            pix(vt[v].x, vt[v].y, vt[v].vis, vt[v].bg, vt[v].tr);
            tick();
            chk($sformatf("vec%0d rom_addr0", v), 32'(rom_addr[0*14 +: 14]), 32'(vt[v].a0));
            chk($sformatf("vec%0d rom_addr1", v), 32'(rom_addr[1*14 +: 14]), 32'(vt[v].a1));
            chk($sformatf("vec%0d rom_addr2", v), 32'(rom_addr[2*14 +: 14]), 32'(vt[v].a2));
            chk($sformatf("vec%0d rom_addr3", v), 32'(rom_addr[3*14 +: 14]), 32'(vt[v].a3));
            tick(); tick();
            chk($sformatf("vec%0d rgb_out", v),   32'(rgb_out),   32'(vt[v].rgb));
            chk($sformatf("vec%0d hit_id", v),    32'(hit_id),    32'(vt[v].hid));
            chk($sformatf("vec%0d valid_out", v), 32'(valid_out), 32'(vt[v].vout));
        end

        // Collision: set, sticky, cleared by frame_start, blocked when blanked, set beats clear
        pix(10'd0, 9'd0, 1'b0, 12'h000, 4'h0);
        tick3();
        fs_pulse();
        chk("coll cleared at frame", 32'(collision), 32'h0);
        pix(10'd163, 9'd113, 1'b1, 12'h111, 4'h0);
        tick3();
        chk("coll set on overlap", 32'(collision), 32'h1);
        chk("coll winner rgb",     32'(rgb_out),   32'hF00);
        pix(10'd163, 9'd113, 1'b0, 12'h111, 4'h0);
        tick3();
        chk("coll sticky", 32'(collision), 32'h1);
        fs_pulse();
        chk("coll clear next frame", 32'(collision), 32'h0);
        tick3();
        chk("coll not set when blanked", 32'(collision), 32'h0);
        pix(10'd163, 9'd113, 1'b1, 12'h111, 4'h1);
        tick3();
        chk("keyed sprite0 rgb", 32'(rgb_out),   32'h0F0);
        chk("keyed sprite0 coll", 32'(collision), 32'h0);
        pix(10'd163, 9'd113, 1'b1, 12'h111, 4'h0);
        tick3();
        chk("coll set again", 32'(collision), 32'h1);
        fs_pulse();
        chk("coll set wins over clear", 32'(collision), 32'h1);

        // Config double-buffering
        pix(10'd0, 9'd0, 1'b0, 12'h000, 4'h0);
        cfg(2'd0, 1'b1, 10'd200, 9'd50);
        pix(10'd100, 9'd50, 1'b1, 12'h777, 4'h0);
        tick3();
        chk("pending not applied rgb", 32'(rgb_out), 32'hF00);
        fs_pulse();
        tick3();
        chk("old x after frame rgb", 32'(rgb_out), 32'h777);
        chk("old x after frame hid", 32'(hit_id),  32'h0);
        pix(10'd200, 9'd50, 1'b1, 12'h777, 4'h0);
        tick3();
        chk("new x after frame rgb", 32'(rgb_out), 32'hF00);
        chk("new x after frame hid", 32'(hit_id),  32'h4);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_x = 10'd300; cfg_y = 9'd50;
        fs_pulse();
        cfg_we = 1'b0;
        pix(10'd300, 9'd50, 1'b1, 12'h777, 4'h0);
        tick3();
        chk("coincident write rgb", 32'(rgb_out), 32'hF00);

        // Animation step after 16 frame_start pulses
        while (fs_count < 16) fs_pulse();
        tick();
        chk("anim1 rom_addr0 origin", 32'(rom_addr[13:0]), 32'd4096);
        pix(10'd301, 9'd51, 1'b1, 12'h777, 4'h0);
        tick();
        chk("anim1 rom_addr0 offset", 32'(rom_addr[13:0]), 32'd4161);
        tick(); tick();
        chk("anim1 rgb", 32'(rgb_out), 32'hF00);

        // Reset mid-stream
        rst = 1'b1;
        tick();
        chk("midrst rgb_out",   32'(rgb_out),   32'h0);
        chk("midrst valid_out", 32'(valid_out), 32'h0);
        chk("midrst hit_id",    32'(hit_id),    32'h0);
        chk("midrst rom_addr0", 32'(rom_addr[13:0]), 32'h0);
        rst = 1'b0;
        tick();
        chk("banks cleared rom_addr0", 32'(rom_addr[13:0]), 32'h0);
        cfg(2'd0, 1'b1, 10'd300, 9'd50);
        fs_pulse();
        tick();
        chk("frame_cnt restarted addr", 32'(rom_addr[13:0]), 32'd65);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
